// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: two requester ports, the memory side and lock status.
// The slave modport is the arbiter; the master modport is whatever drives requests and models the RAM.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0_i, we0_i;
  logic [AW-1:0] addr0_i;
  logic [DW-1:0] wdata0_i;
  logic          gnt0_o, stall0_o, rvalid0_o;
  logic [DW-1:0] rdata0_o;

  logic          req1_i, we1_i, lock1_i;
  logic [AW-1:0] addr1_i;
  logic [DW-1:0] wdata1_i;
  logic          gnt1_o, rvalid1_o;
  logic [DW-1:0] rdata1_o;

  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          locked_o;

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    output gnt0_o, stall0_o, rvalid0_o, rdata0_o,
    input  req1_i, we1_i, lock1_i, addr1_i, wdata1_i,
    output gnt1_o, rvalid1_o, rdata1_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output locked_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i,
    input  gnt0_o, stall0_o, rvalid0_o, rdata0_o,
    output req1_i, we1_i, lock1_i, addr1_i, wdata1_i,
    input  gnt1_o, rvalid1_o, rdata1_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  locked_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: core (port 0) vs debug/loader (port 1) with bounded burst lock.
// Define DMEM_ARB_RR_EN for round-robin IDLE arbitration; default is fixed priority to port 0.
module dmem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  dmem_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, LOCK1 = 1'b1} state_t;
  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  state_t     state_q, state_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       rel_q, rel_d;
  logic [1:0] rd_pend_q, rd_pend_d;
  logic       gnt0, gnt1;
`ifdef DMEM_ARB_RR_EN
  logic       last_q, last_d;  // 1: port 1 was granted most recently
`endif

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rel_d      = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_d     = last_q;
`endif
    if (state_q == LOCK1) begin
      gnt1 = bus.req1_i;
      gnt0 = bus.req0_i & ~bus.req1_i;
    end else if (rel_q) begin
      // forced release: port 1 masked for one cycle so the core gets through
      gnt0 = bus.req0_i;
    end else begin
`ifdef DMEM_ARB_RR_EN
      if (bus.req0_i && bus.req1_i) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = bus.req0_i;
        gnt1 = bus.req1_i;
      end
`else
      gnt0 = bus.req0_i;
      gnt1 = bus.req1_i & ~bus.req0_i;
`endif
    end
    // grants are combinational, so hold them low while reset is asserted
    if (!rst_ni) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (gnt1 && bus.lock1_i) begin
          state_d    = LOCK1;
          lock_cnt_d = 8'd1;
        end
      end
      LOCK1: begin
        if (gnt1 && (lock_cnt_q + 8'd1 >= MAX_CNT)) begin
          state_d    = IDLE;
          lock_cnt_d = 8'd0;
          rel_d      = 1'b1;
        end else if (!bus.lock1_i) begin
          state_d    = IDLE;
          lock_cnt_d = 8'd0;
        end else if (gnt1 && lock_cnt_q != MAX_CNT) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef DMEM_ARB_RR_EN
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
`endif
    rd_pend_d = {gnt1 & ~bus.we1_i, gnt0 & ~bus.we0_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lock_cnt_q <= 8'd0;
      rel_q      <= 1'b0;
      rd_pend_q  <= 2'b00;
`ifdef DMEM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rel_q      <= rel_d;
      rd_pend_q  <= rd_pend_d;
`ifdef DMEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.gnt0_o      = gnt0;
  assign bus.gnt1_o      = gnt1;
  assign bus.stall0_o    = bus.req0_i & ~gnt0 & rst_ni;
  assign bus.locked_o    = (state_q == LOCK1);

  assign bus.mem_en_o    = gnt0 | gnt1;
  assign bus.mem_we_o    = gnt0 ? bus.we0_i    : (gnt1 ? bus.we1_i    : 1'b0);
  assign bus.mem_addr_o  = gnt0 ? bus.addr0_i  : (gnt1 ? bus.addr1_i  : {AW{1'b0}});
  assign bus.mem_wdata_o = gnt0 ? bus.wdata0_i : (gnt1 ? bus.wdata1_i : {DW{1'b0}});

  assign bus.rvalid0_o   = rd_pend_q[0];
  assign bus.rvalid1_o   = rd_pend_q[1];
  assign bus.rdata0_o    = rd_pend_q[0] ? bus.mem_rdata_i : {DW{1'b0}};
  assign bus.rdata1_o    = rd_pend_q[1] ? bus.mem_rdata_i : {DW{1'b0}};
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (core load/store path, driven from the ALU address and rs2 store data) and port 1 (debug/program-loader master).
- Grants one access per cycle and returns read data with fixed 1-cycle latency.
- Port 1 may lock the memory for bursts, bounded by a lock limit so the core is never starved.
- Produces a stall for the core whenever its request is not granted.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
MAX_LOCK, 16, maximum consecutive locked grants to port 1 before a forced release cycle (2..255)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req0_i  in  1  port 0 (core) access request
we0_i  in  1  port 0 write enable (1=store, 0=load)
addr0_i  in  AW  port 0 byte address
wdata0_i  in  DW  port 0 write data
gnt0_o  out  1  port 0 granted this cycle
stall0_o  out  1  core stall, = req0_i & ~gnt0_o
rvalid0_o  out  1  port 0 read data valid
rdata0_o  out  DW  port 0 read data
req1_i  in  1  port 1 (debug/loader) access request
we1_i  in  1  port 1 write enable
lock1_i  in  1  port 1 requests burst lock
addr1_i  in  AW  port 1 byte address
wdata1_i  in  DW  port 1 write data
gnt1_o  out  1  port 1 granted this cycle
rvalid1_o  out  1  port 1 read data valid
rdata1_o  out  DW  port 1 read data
mem_en_o  out  1  memory access enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  AW  memory address
mem_wdata_o  out  DW  memory write data
mem_rdata_i  in  DW  memory read data, valid 1 cycle after a read with mem_en_o=1
locked_o  out  1  arbiter in LOCK1 state

Behaviour:
- Grant logic is combinational from the req inputs and registered state; at most one of gnt0_o/gnt1_o is high per cycle.
- Memory side mirrors the granted port in the same cycle: mem_en_o=gnt0_o|gnt1_o; mem_we_o, mem_addr_o and mem_wdata_o come from the granted port. With no grant, all mem_* outputs are 0.
- Read return: the granted port and a read flag are registered.
  - Next cycle, rvalidN_o=1 for the port that had the read grant; rdataN_o = mem_rdata_i.
  - The non-owning rdata output is 0.
  - Writes never raise rvalid.
- States: IDLE, LOCK1.
- IDLE, both requesting: the higher-priority port wins (see Optional Feature). Single requester: that port wins.
- IDLE -> LOCK1: when port 1 is granted with lock1_i=1; lock_cnt loads 1.
- In LOCK1:
  - Port 1 has absolute priority; each gnt1_o increments lock_cnt.
  - Cycles with req1_i=0 grant port 0 if it requests, but stay in LOCK1.
- LOCK1 -> IDLE on either condition:
  - lock1_i=0 sampled on any cycle.
  - lock_cnt reaching MAX_LOCK. The following cycle is a forced release: port 1 is masked and port 0 is granted if requesting. After the forced release, lock1_i=1 may re-enter LOCK1.
- lock_cnt saturates at MAX_LOCK and is 8 bits wide.
- Reset (async, any time, including mid-burst or with a read outstanding):
  - All outputs 0; state IDLE; lock_cnt 0; pending read flags cleared.
  - No rvalid is produced after reset deasserts.
  - last_grant resets to port 1, so port 0 wins the first contention.
- Requests are level-based; a requester holds reqN_i until it sees gntN_o. Changing address or data while ungranted is legal.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin in IDLE. On contention, the port not granted most recently wins; last_grant updates on every grant.
- Undefined: fixed priority, port 0 (core) always wins IDLE contention. last_grant is not implemented.
- LOCK1 behaviour is identical in both builds.

Test Plan:
- Reset, then a single read: req0_i=1, we0_i=0, addr0_i=0x10, with memory holding 0xDEADBEEF at 0x10 -> gnt0_o=1, mem_addr_o=0x10 in that cycle; next cycle rvalid0_o=1, rdata0_o=0xDEADBEEF; stall0_o=0 throughout.
- Contention in IDLE, both ports request reads for 4 cycles:
  - Fixed priority -> gnt0 on all 4 cycles, stall-free core.
  - DMEM_ARB_RR_EN -> grants alternate 0,1,0,1.
- Locked burst: port 1 writes 20 words with lock1_i=1 and MAX_LOCK=16 while req0_i=1 -> gnt1 for 16 cycles with stall0_o=1, then 1 cycle gnt0, then gnt1 resumes.
- Lock dropped: lock1_i=0 after 3 locked grants -> locked_o falls the next cycle; contention is then resolved by IDLE priority.
- Reset mid-read: assert rst_ni=0 the cycle after a port 1 read grant -> rvalid1_o stays 0; all mem_* outputs are 0 while in reset.
- Write then read-back via port 0 (store 0x12345678 at 0x40, load 0x40) -> no rvalid on the write; rdata0_o=0x12345678 one cycle after the load grant.
